// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the decode stage.
// Holds the RV32I load/store width codes (funct3), the responder FSM state
// encoding, and a helper that flags width codes that are not legal for the
// given access direction.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unsigned widths exist only for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic for the data-memory responder.
// Ports:
//   funct3      - access width code
//   addr_lo     - byte offset within the word
//   wdata       - right-aligned store data
//   rword       - full 32-bit word read from storage
//   byte_en     - byte lanes written by a store
//   wdata_lanes - store data replicated onto every candidate lane
//   rdata_ext   - extracted and sign/zero-extended load data
//   misaligned  - halfword on odd address or word not on a 4-byte boundary
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rbyte_s;
    logic [15:0] rhalf_s;

    // Lane selection, store replication and load extension per width code.
    always_comb begin
        case (addr_lo)
            2'd0:    rbyte_s = rword[7:0];
            2'd1:    rbyte_s = rword[15:8];
            2'd2:    rbyte_s = rword[23:16];
            default: rbyte_s = rword[31:24];
        endcase
        rhalf_s     = addr_lo[1] ? rword[31:16] : rword[15:0];
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0000_0000;
        rdata_ext   = 32'h0000_0000;
        misaligned  = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{rbyte_s[7]}}, rbyte_s};
            end
            F3_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {24'h00_0000, rbyte_s};
            end
            F3_H: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{rhalf_s[15]}}, rhalf_s};
                misaligned  = addr_lo[0];
            end
            F3_HU: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {16'h0000, rhalf_s};
                misaligned  = addr_lo[0];
            end
            F3_W: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rword;
                misaligned  = (addr_lo != 2'b00);
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage of an RV32I pipeline.
// Accepts one load/store at a time, waits WAIT_CYCLES, then produces a
// one-cycle response. Storage is a word array that is never reset.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_valid/we    - request present, store (1) or load (0)
//   req_funct3      - width code; req_addr byte address; req_wdata store data
//   req_ready       - high only in IDLE
//   rsp_valid/err   - response pulse and error flag
//   rsp_rdata       - extended load data, zero for stores and errors
//   stall           - hold upstream pipeline registers
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lat_we_q, lat_we_d;
    logic [2:0]  lat_funct3_q, lat_funct3_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept_s, enter_resp_s, err_s, wr_en_s;
    logic             op_we_s;
    logic [2:0]       op_funct3_s;
    logic [31:0]      op_addr_s, op_wdata_s, rword_s, wdata_lanes_s, rdata_ext_s;
    logic [IDX_W-1:0] op_idx_s;
    logic [3:0]       byte_en_s;
    logic             misaligned_s;

    assign accept_s = req_valid && (state_q == ST_IDLE);

    // With zero wait the access happens on the accept edge itself, so the
    // live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we_s     = req_we;
            op_funct3_s = req_funct3;
            op_addr_s   = req_addr;
            op_wdata_s  = req_wdata;
        end else begin
            op_we_s     = lat_we_q;
            op_funct3_s = lat_funct3_q;
            op_addr_s   = lat_addr_q;
            op_wdata_s  = lat_wdata_q;
        end
    end

    assign op_idx_s     = op_addr_s[IDX_W+1:2];
    assign rword_s      = mem_q[op_idx_s];
    assign enter_resp_s = (accept_s && (WAIT_CYCLES == 0)) ||
                          ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign err_s        = f3_illegal(op_we_s, op_funct3_s) || misaligned_s ||
                          ((op_addr_s >> (IDX_W + 2)) != 32'd0);
    assign wr_en_s      = enter_resp_s && op_we_s && !err_s && !rst;

    dmem_lane_align u_lane_align (
        .funct3      (op_funct3_s),
        .addr_lo     (op_addr_s[1:0]),
        .wdata       (op_wdata_s),
        .rword       (rword_s),
        .byte_en     (byte_en_s),
        .wdata_lanes (wdata_lanes_s),
        .rdata_ext   (rdata_ext_s),
        .misaligned  (misaligned_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; stall drops in RESP so the pipeline captures rsp_rdata.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        stall     = req_valid && (state_q != ST_RESP);
    end

    // Wait counter, request latch and response next values.
    always_comb begin
        cnt_d        = cnt_q;
        lat_we_d     = lat_we_q;
        lat_funct3_d = lat_funct3_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        if (accept_s) begin
            cnt_d        = WAIT_INIT;
            lat_we_d     = req_we;
            lat_funct3_d = req_funct3;
            lat_addr_d   = req_addr;
            lat_wdata_d  = req_wdata;
        end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        rsp_valid_d = enter_resp_s;
        rsp_err_d   = enter_resp_s && err_s;
        if (enter_resp_s && !err_s && !op_we_s) begin
            rsp_rdata_d = rdata_ext_s;
        end else begin
            rsp_rdata_d = 32'h0000_0000;
        end
    end

    // Counter, request latch and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            lat_we_q     <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_addr_q   <= 32'h0000_0000;
            lat_wdata_q  <= 32'h0000_0000;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
        end else begin
            cnt_q        <= cnt_d;
            lat_we_q     <= lat_we_d;
            lat_funct3_q <= lat_funct3_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Storage array: not reset, written per byte lane on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_q[op_idx_s][8*b +: 8] <= wdata_lanes_s[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances share the request
// fields; each has its own req_valid and rst:
//   index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0, index 2: WAIT_CYCLES=3.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  req_valid_v;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ready_v;
    logic [2:0]  rsp_valid_v;
    logic [2:0]  rsp_err_v;
    logic [2:0]  stall_v;
    logic [31:0] rsp_rdata_a [3];

    int checks = 0;
    int errors = 0;

    // results of run_op
    int          o_lat;
    int          o_pulses;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_leak;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_v[0]), .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_a[0]),
        .rsp_err(rsp_err_v[0]), .stall(stall_v[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_v[1]), .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_a[1]),
        .rsp_err(rsp_err_v[1]), .stall(stall_v[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst_v[2]), .req_valid(req_valid_v[2]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_v[2]), .rsp_valid(rsp_valid_v[2]), .rsp_rdata(rsp_rdata_a[2]),
        .rsp_err(rsp_err_v[2]), .stall(stall_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    // One request on instance inst; request fields are scrambled right after
    // the accept edge. Records response cycle (1 = cycle after accept edge),
    // data, error, pulse count, and whether outputs were nonzero outside RESP.
    task automatic run_op(input int inst, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid_v[inst] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[inst] = 1'b0;
        req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata;
        o_lat = 0; o_pulses = 0; o_rdata = 32'h0; o_err = 1'b0; o_leak = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rsp_valid_v[inst] === 1'b1) begin
                o_pulses++;
                if (o_lat == 0) begin
                    o_lat = c; o_rdata = rsp_rdata_a[inst]; o_err = rsp_err_v[inst];
                end
            end else if (rsp_rdata_a[inst] !== 32'h0 || rsp_err_v[inst] !== 1'b0) begin
                o_leak = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_v = 3'b111; req_valid_v = 3'b111;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (stall_v !== 3'b111) begin errors++; $display("FAIL reset_stall_valid: got %b expected 111", stall_v); end
        checks++; if (req_ready_v !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", req_ready_v); end
        checks++; if (rsp_valid_v !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", rsp_valid_v); end
        checks++; if (rsp_err_v !== 3'b000) begin errors++; $display("FAIL reset_rsp_err: got %b expected 000", rsp_err_v); end
        checks++; if (rsp_rdata_a[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata_a[0]); end
        req_valid_v = 3'b000;
        #1;
        checks++; if (stall_v !== 3'b000) begin errors++; $display("FAIL reset_stall_idle: got %b expected 000", stall_v); end
        @(posedge clk); #1;
        rst_v = 3'b000;
        @(negedge clk);
        checks++; if (req_ready_v !== 3'b111) begin errors++; $display("FAIL post_reset_ready: got %b expected 111", req_ready_v); end
    endtask

    task automatic test_store_load();
        run_op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", o_lat); end
        checks++; if (o_pulses !== 1) begin errors++; $display("FAIL sw_pulses: got %0d expected 1", o_pulses); end
        checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b expected 00000000/0", o_rdata, o_err); end
        run_op(0, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", o_lat); end
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", o_rdata); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", o_err); end
        checks++; if (o_leak !== 1'b0) begin errors++; $display("FAIL lw_leak: got %b expected 0", o_leak); end
    endtask

    task automatic test_extend();
        run_op(0, 1'b1, 3'b010, 32'h20, 32'h0000_0080);
        run_op(0, 1'b0, 3'b000, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign: got %h expected ffffff80", o_rdata); end
        run_op(0, 1'b0, 3'b100, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zero: got %h expected 00000080", o_rdata); end
        run_op(0, 1'b1, 3'b001, 32'h22, 32'h0000_1234);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sh_err: got %b expected 0", o_err); end
        run_op(0, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'h12340080) begin errors++; $display("FAIL sh_merge: got %h expected 12340080", o_rdata); end
        run_op(0, 1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB);
        run_op(0, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'h1234AB80) begin errors++; $display("FAIL sb_lane1: got %h expected 1234ab80", o_rdata); end
        run_op(0, 1'b0, 3'b001, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFAB80) begin errors++; $display("FAIL lh_sign: got %h expected ffffab80", o_rdata); end
        run_op(0, 1'b0, 3'b101, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'h0000AB80) begin errors++; $display("FAIL lhu_zero: got %h expected 0000ab80", o_rdata); end
        run_op(0, 1'b0, 3'b001, 32'h22, 32'h0);
        checks++; if (o_rdata !== 32'h00001234) begin errors++; $display("FAIL lh_upper: got %h expected 00001234", o_rdata); end
        run_op(0, 1'b0, 3'b000, 32'h23, 32'h0);
        checks++; if (o_rdata !== 32'h00000012) begin errors++; $display("FAIL lb_lane3: got %h expected 00000012", o_rdata); end
    endtask

    task automatic test_errors();
        run_op(0, 1'b0, 3'b010, 32'h13, 32'h0);
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL lw_misaligned: got %b/%h expected 1/00000000", o_err, o_rdata); end
        run_op(0, 1'b1, 3'b001, 32'h21, 32'h0000_5A5A);
        checks++; if (o_err !== 1'b1 || o_lat !== 2) begin errors++; $display("FAIL sh_misaligned: got %b lat %0d expected 1 lat 2", o_err, o_lat); end
        run_op(0, 1'b1, 3'b100, 32'h20, 32'h0000_0077);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL store_bu_illegal: got %b expected 1", o_err); end
        run_op(0, 1'b0, 3'b011, 32'h20, 32'h0);
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL f3_011_illegal: got %b/%h expected 1/00000000", o_err, o_rdata); end
        run_op(0, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (o_rdata !== 32'h1234AB80 || o_err !== 1'b0) begin errors++; $display("FAIL mem_unchanged: got %h/%b expected 1234ab80/0", o_rdata, o_err); end
        run_op(0, 1'b0, 3'b010, 32'h1000, 32'h0);
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL lw_out_of_range: got %b/%h expected 1/00000000", o_err, o_rdata); end
        run_op(0, 1'b1, 32'h0 == 32'h0 ? 3'b010 : 3'b010, 32'hFFC, 32'h0A0B0C0D);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sw_last_word: got %b expected 0", o_err); end
        run_op(0, 1'b0, 3'b010, 32'hFFC, 32'h0);
        checks++; if (o_rdata !== 32'h0A0B0C0D) begin errors++; $display("FAIL lw_last_word: got %h expected 0a0b0c0d", o_rdata); end
        run_op(0, 1'b0, 3'b010, 32'h0, 32'h0);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL lw_word0_aliased: got err %b expected 0", o_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        int pulses;
        exp_data[0] = 32'h11111111; exp_data[1] = 32'h22222222; exp_data[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            run_op(1, 1'b1, 3'b010, 32'(4 * i), exp_data[i]);
            checks++; if (o_lat !== 1) begin errors++; $display("FAIL w0_store_latency[%0d]: got %0d expected 1", i, o_lat); end
        end
        pulses = 0;
        @(posedge clk); #1;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid_v[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (stall_v[1] !== (c % 2 == 0)) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected %b", c, stall_v[1], (c % 2 == 0)); end
            checks++; if (req_ready_v[1] !== (c % 2 == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, req_ready_v[1], (c % 2 == 0)); end
            checks++; if (rsp_valid_v[1] !== (c % 2 == 1)) begin errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", c, rsp_valid_v[1], (c % 2 == 1)); end
            if (rsp_valid_v[1] === 1'b1) pulses++;
            if (c % 2 == 1) begin
                checks++; if (rsp_rdata_a[1] !== exp_data[c / 2]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", c / 2, rsp_rdata_a[1], exp_data[c / 2]); end
            end
            @(posedge clk); #1;
            if (c % 2 == 0) req_addr = 32'(4 * (c / 2 + 1));
        end
        req_valid_v[1] = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        run_op(2, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL w3_latency: got %0d expected 4", o_lat); end
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0000_0055;
        req_valid_v[2] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[2] = 1'b0;
        seen = 0;
        @(posedge clk); #1;
        rst_v[2] = 1'b1;
        @(negedge clk);
        if (rsp_valid_v[2] === 1'b1) seen++;
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid_v[2] === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_wait_no_rsp: got %0d pulses expected 0", seen); end
        checks++; if (req_ready_v[2] !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready_v[2]); end
        run_op(2, 1'b0, 3'b010, 32'h40, 32'h0);
        checks++; if (o_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_wait_no_commit: got %h expected cafef00d", o_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
